// File: rtl/palt_nios_irq_pkg.sv
// Shared constants, register-map addresses and helpers for the Nios interrupt aggregator.
package palt_nios_irq_pkg;

  localparam int IRQ_MAX = 16;
  localparam int ID_W    = 4;

  localparam logic [2:0] ADDR_PENDING  = 3'd0;
  localparam logic [2:0] ADDR_MASK     = 3'd1;
  localparam logic [2:0] ADDR_EDGE_SEL = 3'd2;
  localparam logic [2:0] ADDR_ACTIVE   = 3'd3;
  localparam logic [2:0] ADDR_HIGHEST  = 3'd4;
  localparam logic [2:0] ADDR_FORCE    = 3'd5;

  // Slave write request as seen in one cycle.
  typedef struct packed {
    logic        wr;
    logic [2:0]  addr;
    logic [15:0] data;
  } bus_req_t;

  // HIGHEST register layout.
  typedef struct packed {
    logic                    valid;
    logic [IRQ_MAX-ID_W-2:0] rsvd;
    logic [ID_W-1:0]         id;
  } highest_t;

  // Index of the lowest set bit (bit 0 = highest priority); 0 when none set.
  function automatic logic [ID_W-1:0] lowest_id(input logic [IRQ_MAX-1:0] v);
    lowest_id = '0;
    for (int i = IRQ_MAX - 1; i >= 0; i--)
      if (v[i]) lowest_id = ID_W'(i);
  endfunction

endpackage

// File: rtl/palt_nios_irq_sync.sv
// One request line: SYNC_STAGES-deep synchroniser, then a previous-value flop for rise detection.
module palt_nios_irq_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic s,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sq;
  logic                   p;

  // Shift the raw input through the synchroniser chain and keep last synced value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sq <= '0;
      p  <= 1'b0;
    end else begin
      sq <= {sq[SYNC_STAGES-2:0], d};
      p  <= sq[SYNC_STAGES-1];
    end
  end

  assign s    = sq[SYNC_STAGES-1];
  assign rise = s & ~p;

endmodule

// File: rtl/palt_nios_irq_ctrl.sv
// Interrupt aggregator: per-line sync, level/edge pending latch, mask, priority encode, 16-bit slave.
module palt_nios_irq_ctrl
  import palt_nios_irq_pkg::*;
#(
  parameter int NUM_IRQ     = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [2:0]         address,
  input  logic               chipselect,
  input  logic               write_n,
  input  logic [15:0]        writedata,
  output logic [15:0]        readdata,
  input  logic [NUM_IRQ-1:0] irq_in,
  output logic               irq,
  output logic [3:0]         irq_id
);

  // Bits at or above NUM_IRQ are forced to zero everywhere through this mask.
  localparam logic [IRQ_MAX-1:0] IMPL = {IRQ_MAX{1'b1}} >> (IRQ_MAX - NUM_IRQ);

  logic [IRQ_MAX-1:0] s_v, rise_v;
  logic [IRQ_MAX-1:0] pending, mask, edge_sel, active, pend_nxt;
  logic [IRQ_MAX-1:0] w1c, force_v, edge_chg, edge_nxt;
  bus_req_t           req;
  highest_t           hi;

  for (genvar i = 0; i < IRQ_MAX; i++) begin : g_line
    if (i < NUM_IRQ) begin : g_impl
      palt_nios_irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (irq_in[i]),
        .s       (s_v[i]),
        .rise    (rise_v[i])
      );
    end else begin : g_none
      assign s_v[i]    = 1'b0;
      assign rise_v[i] = 1'b0;
    end
  end

  assign req = '{wr: chipselect & ~write_n, addr: address, data: writedata};

  assign w1c      = (req.wr && req.addr == ADDR_PENDING)  ? req.data : '0;
  assign force_v  = (req.wr && req.addr == ADDR_FORCE)    ? req.data : '0;
  // Any mode flip drops that bit's pending state, including a rise in the same cycle.
  assign edge_chg = (req.wr && req.addr == ADDR_EDGE_SEL) ? (req.data ^ edge_sel) : '0;
  // Edge bits: set (rise or force) beats W1C so an edge arriving during a clear is kept.
  assign edge_nxt = (pending & ~w1c) | rise_v | force_v;
  assign pend_nxt = IMPL & ~edge_chg & ((edge_sel & edge_nxt) | (~edge_sel & s_v));

  assign active = pending & mask;
  assign hi     = '{valid: |active, rsvd: '0, id: lowest_id(active)};

  // Pending latch and the two RW configuration registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending  <= '0;
      mask     <= '0;
      edge_sel <= '0;
    end else begin
      pending <= pend_nxt;
      if (req.wr && req.addr == ADDR_MASK)     mask     <= req.data & IMPL;
      if (req.wr && req.addr == ADDR_EDGE_SEL) edge_sel <= req.data & IMPL;
    end
  end

  // Registered CPU request and winning source index.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq    <= 1'b0;
      irq_id <= '0;
    end else begin
      irq    <= hi.valid;
      irq_id <= hi.id;
    end
  end

  // Read mux registered every cycle from address; chipselect is not needed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      case (address)
        ADDR_PENDING:  readdata <= pending;
        ADDR_MASK:     readdata <= mask;
        ADDR_EDGE_SEL: readdata <= edge_sel;
        ADDR_ACTIVE:   readdata <= active;
        ADDR_HIGHEST:  readdata <= hi;
        default:       readdata <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_palt_nios_irq_ctrl.sv
// Self-checking bench: directed steps plus random traffic against a behavioural model.
module tb_palt_nios_irq_ctrl;

  localparam int NUM_IRQ = 8;
  localparam int SS      = 2;
  localparam logic [15:0] IMPL = 16'h00FF;

  logic               clk = 1'b0;
  logic               reset_n;
  logic [2:0]         address;
  logic               chipselect;
  logic               write_n;
  logic [15:0]        writedata;
  logic [15:0]        readdata;
  logic [NUM_IRQ-1:0] irq_in;
  logic               irq;
  logic [3:0]         irq_id;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  logic [15:0]        m_pend, m_mask, m_edge, m_rd;
  logic               m_irq;
  logic [3:0]         m_id;
  logic [NUM_IRQ-1:0] hist[$];   // hist[j] = irq_in sampled j+1 edges ago

  palt_nios_irq_ctrl #(.NUM_IRQ(NUM_IRQ), .SYNC_STAGES(SS)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq_in     (irq_in),
    .irq        (irq),
    .irq_id     (irq_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pend = '0; m_mask = '0; m_edge = '0; m_rd = '0; m_irq = 1'b0; m_id = '0;
    hist.delete();
    for (int j = 0; j <= SS; j++) hist.push_back('0);
  endtask

  // Position of the lowest set bit, by arithmetic isolation of that bit.
  function automatic logic [3:0] low_bit(input logic [15:0] v);
    logic [15:0] iso;
    iso = v & (~v + 16'd1);
    return (v == 0) ? 4'd0 : 4'($clog2(iso));
  endfunction

  // One clock edge of the model, from the values present just before the edge.
  task automatic model_step();
    logic [15:0] act, np, s_pre, p_pre;
    logic        we, rise;
    if (!reset_n) begin
      model_reset();
      return;
    end
    we    = chipselect && !write_n;
    s_pre = 16'(hist[SS-1]);
    p_pre = 16'(hist[SS]);
    act   = m_pend & m_mask;
    case (address)
      3'd0:    m_rd = m_pend;
      3'd1:    m_rd = m_mask;
      3'd2:    m_rd = m_edge;
      3'd3:    m_rd = act;
      3'd4:    m_rd = (act != 0) ? (16'h8000 | 16'(low_bit(act))) : 16'h0000;
      default: m_rd = 16'h0000;
    endcase
    m_irq = (act != 0);
    m_id  = low_bit(act);
    np = m_pend;
    for (int i = 0; i < NUM_IRQ; i++) begin
      rise = s_pre[i] && !p_pre[i];
      if (we && address == 3'd2 && writedata[i] != m_edge[i]) np[i] = 1'b0;
      else if (!m_edge[i])                                   np[i] = s_pre[i];
      else if (rise || (we && address == 3'd5 && writedata[i])) np[i] = 1'b1;
      else if (we && address == 3'd0 && writedata[i])        np[i] = 1'b0;
    end
    if (we && address == 3'd1) m_mask = writedata & IMPL;
    if (we && address == 3'd2) m_edge = writedata & IMPL;
    m_pend = np;
    hist.push_front(irq_in);
    void'(hist.pop_back());
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    chk("irq", {15'b0, irq}, {15'b0, m_irq});
    chk("irq_id", {12'b0, irq_id}, {12'b0, m_id});
    chk("readdata", readdata, m_rd);
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    cyc();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input string tag, input logic [2:0] a, input logic [15:0] exp);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    cyc();
    chk(tag, readdata, exp);
    chipselect = 1'b0;
  endtask

  initial begin
    logic [NUM_IRQ-1:0] flip;
    int r;
    reset_n = 1'b0; address = '0; chipselect = 1'b0; write_n = 1'b1;
    writedata = '0; irq_in = '0;
    model_reset();

    // 1: reset held, inputs toggling, every address reads zero
    for (int k = 0; k < 6; k++) begin
      irq_in = k[0] ? 8'hFF : 8'h00;
      address = 3'(k); chipselect = 1'b1;
      cyc();
      chk("rst_read", readdata, 16'h0000);
      chk("rst_irq", {15'b0, irq}, 16'h0000);
    end
    irq_in = '0; chipselect = 1'b0;
    #2 reset_n = 1'b1;
    repeat (4) cyc();
    for (int k = 0; k < 6; k++) rd("post_rst_read", 3'(k), 16'h0000);

    // 2: level source latency
    wr(3'd1, 16'h0001);
    irq_in = 8'h01;
    for (int k = 1; k <= 4; k++) begin
      cyc();
      chk("lvl_rise", {15'b0, irq}, 16'(k == 4));
    end
    irq_in = 8'h00;
    for (int k = 1; k <= 4; k++) begin
      cyc();
      chk("lvl_fall", {15'b0, irq}, 16'(k < 4));
    end

    // 3: edge latch, W1C, and set-beats-clear
    wr(3'd2, 16'h0004);
    wr(3'd1, 16'h0004);
    irq_in = 8'h04; cyc(); irq_in = 8'h00;
    repeat (5) cyc();
    rd("edge_held", 3'd0, 16'h0004);
    chk("edge_irq", {15'b0, irq}, 16'h0001);
    wr(3'd0, 16'h0004);
    cyc();
    chk("w1c_irq", {15'b0, irq}, 16'h0000);
    rd("w1c_pend", 3'd0, 16'h0000);
    irq_in = 8'h04;
    wr(3'd5, 16'h0004);
    irq_in = 8'h00;
    cyc();
    wr(3'd0, 16'h0004);
    rd("set_wins", 3'd0, 16'h0004);

    // 4: priority encode
    wr(3'd0, 16'h00FF);
    wr(3'd2, 16'h00FF);
    wr(3'd5, 16'h0028);
    wr(3'd1, 16'h00FF);
    cyc();
    chk("prio_id3", {12'b0, irq_id}, 16'h0003);
    rd("highest", 3'd4, 16'h8003);
    wr(3'd0, 16'h0008);
    cyc();
    chk("prio_id5", {12'b0, irq_id}, 16'h0005);

    // 5: mask gating and mode switch clearing pending
    wr(3'd0, 16'h00FF);
    wr(3'd5, 16'h0010);
    wr(3'd1, 16'h0000);
    cyc();
    chk("masked_irq", {15'b0, irq}, 16'h0000);
    rd("masked_pend", 3'd0, 16'h0010);
    wr(3'd1, 16'h0010);
    cyc();
    chk("unmask_irq", {15'b0, irq}, 16'h0001);
    wr(3'd2, 16'h00EF);
    rd("mode_clr", 3'd0, 16'h0000);

    // 6: asynchronous reset with irq high and a read in flight
    wr(3'd0, 16'h00FF);
    wr(3'd2, 16'h0000);
    wr(3'd1, 16'h00FF);
    irq_in = 8'h01;
    repeat (6) cyc();
    chk("pre_rst_irq", {15'b0, irq}, 16'h0001);
    address = 3'd3; chipselect = 1'b1;
    cyc();
    chk("pre_rst_rd", readdata, 16'h0001);
    #3 reset_n = 1'b0;
    #1 model_reset();
    chk("async_irq", {15'b0, irq}, 16'h0000);
    chk("async_rd", readdata, 16'h0000);
    chk("async_id", {12'b0, irq_id}, 16'h0000);
    chipselect = 1'b0;
    repeat (2) cyc();
    #3 reset_n = 1'b1;
    repeat (6) cyc();

    // Random traffic against the model, all address and data values
    for (int n = 0; n < 600; n++) begin
      flip = '0;
      for (int b = 0; b < NUM_IRQ; b++) flip[b] = ($urandom_range(0, 7) == 0);
      irq_in = irq_in ^ flip;
      r = $urandom_range(0, 9);
      address = 3'($urandom_range(0, 7));
      writedata = 16'($urandom);
      chipselect = (r < 6);
      write_n = !(r < 3);
      cyc();
    end
    chipselect = 1'b0; write_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
